// File: rtl/ber_checker_if.sv
// ber_checker_if: symbol-stream and result bundle for the BER checker.
// Latency: wires only; the checker registers every output it drives here.
// Backpressure: none; the symbol strobe i_enable is accepted unconditionally.
//
// Signals:
//   i_enable    symbol strobe, one symbol per high cycle
//   i_rx_sym    downsampled received symbol (decision bit is the MSB)
//   i_ref_bit   transmitter PRBS reference bit, aligned to i_enable
//   o_lock      latency found, counting active
//   o_latency   selected latency, valid while o_lock=1
//   o_bit_count symbols compared since lock
//   o_err_count mismatches since lock
// Modports: master drives the symbol stream and observes results; slave is the checker.
interface ber_checker_if #(
  parameter int WL      = 2,
  parameter int MAX_LAT = 16,
  parameter int CNT_W   = 32
) ();

  localparam int LAT_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  logic             i_enable;
  logic [WL-1:0]    i_rx_sym;
  logic             i_ref_bit;
  logic             o_lock;
  logic [LAT_W-1:0] o_latency;
  logic [CNT_W-1:0] o_bit_count;
  logic [CNT_W-1:0] o_err_count;

  modport master (
    output i_enable,
    output i_rx_sym,
    output i_ref_bit,
    input  o_lock,
    input  o_latency,
    input  o_bit_count,
    input  o_err_count
  );

  modport slave (
    input  i_enable,
    input  i_rx_sym,
    input  i_ref_bit,
    output o_lock,
    output o_latency,
    output o_bit_count,
    output o_err_count
  );

endinterface

// File: rtl/ber_checker.sv
// ber_checker: searches the reference latency with fewest hard-decision errors, then counts bits/errors.
// Latency: one cycle from an enabled symbol to the registered lock/latency/counter update.
// Backpressure: none; i_enable=0 freezes all state, every enabled symbol is consumed.
//
// Ports:
//   i_clk    clock, rising edge
//   i_reset  synchronous active-high reset (priority over i_enable)
//   bus      ber_checker_if.slave: i_enable, i_rx_sym, i_ref_bit in; o_lock, o_latency,
//            o_bit_count, o_err_count out
// Optional feature: define BER_CHECKER_RELOCK_EN to re-enter the search when a locked
// window of WINDOW symbols sees RELOCK_TH or more errors. Without it LOCK is terminal.
module ber_checker #(
  parameter int WL        = 2,
  parameter int MAX_LAT   = 16,
  parameter int WINDOW    = 64,
  parameter int CNT_W     = 32,
  parameter int RELOCK_TH = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  ber_checker_if.slave  bus
);

  localparam int LAT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  // Stored history excludes the current reference bit, which is tapped combinationally.
  localparam int SR_W    = (MAX_LAT > 1) ? MAX_LAT - 1 : 1;
  localparam int WCNT_W  = $clog2(WINDOW);
  // Window error accumulator must hold a full window and the relock threshold.
  localparam int WIN_MAX = (RELOCK_TH > WINDOW) ? RELOCK_TH : WINDOW;
  localparam int WIN_W   = $clog2(WIN_MAX + 1);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCK   = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic [SR_W-1:0]    dly_q;
  logic [SR_W:0]      dly_vec;
  logic [LAT_W-1:0]   cand_q;
  logic [LAT_W-1:0]   lat_q;
  logic [LAT_W-1:0]   best_lat_q;
  logic [LAT_W-1:0]   tap_sel;
  logic [LAT_W-1:0]   lock_lat;
  logic [WCNT_W-1:0]  win_cnt_q;
  logic [WIN_W-1:0]   win_err_q;
  logic [WIN_W-1:0]   win_total;
  logic [WIN_W-1:0]   best_err_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [CNT_W-1:0]   err_cnt_q;
  logic               lock_q;
  logic               rx_bit;
  logic               mismatch;
  logic               win_last;
  logic               better;
  logic               search_win_end;
  logic               go_lock;
  logic               unused_sym_lsbs;
`ifdef BER_CHECKER_RELOCK_EN
  logic               go_search;
`endif

  // Only the MSB carries the hard decision; the remaining bits are soft information.
  assign rx_bit          = bus.i_rx_sym[WL-1];
  assign unused_sym_lsbs = ^bus.i_rx_sym;

  // dly_vec[k] is the reference from k enables earlier; dly_vec[0] is the live bit.
  assign dly_vec   = {dly_q, bus.i_ref_bit};
  assign tap_sel   = (state_q == ST_LOCK) ? lat_q : cand_q;
  assign mismatch  = rx_bit ^ dly_vec[tap_sel];

  assign win_last  = (win_cnt_q == WCNT_W'(WINDOW - 1));
  // Errors of the whole window including the symbol being consumed now.
  assign win_total = win_err_q + WIN_W'(mismatch);
  // Strict compare: on a tie the earlier (lower) latency is kept.
  assign better    = (win_total < best_err_q);
  // The final candidate's own result must be considered on the locking enable.
  assign lock_lat  = better ? cand_q : best_lat_q;

  always_comb begin
    state_d        = state_q;
    search_win_end = 1'b0;
    go_lock        = 1'b0;
`ifdef BER_CHECKER_RELOCK_EN
    go_search      = 1'b0;
`endif
    if (bus.i_enable) begin
      case (state_q)
        ST_SEARCH: begin
          if (win_last) begin
            search_win_end = 1'b1;
            if (cand_q == LAT_W'(MAX_LAT - 1)) begin
              go_lock = 1'b1;
              state_d = ST_LOCK;
            end
          end
        end
        ST_LOCK: begin
`ifdef BER_CHECKER_RELOCK_EN
          if (win_last && (win_total >= WIN_W'(RELOCK_TH))) begin
            go_search = 1'b1;
            state_d   = ST_SEARCH;
          end
`endif
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_SEARCH;
      dly_q      <= '0;
      cand_q     <= '0;
      lat_q      <= '0;
      best_lat_q <= '0;
      best_err_q <= '1;
      win_cnt_q  <= '0;
      win_err_q  <= '0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      lock_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.i_enable) begin
        dly_q <= dly_vec[SR_W-1:0];
        if (state_q == ST_SEARCH) begin
          if (search_win_end) begin
            win_cnt_q <= '0;
            win_err_q <= '0;
            if (better) begin
              best_err_q <= win_total;
              best_lat_q <= cand_q;
            end
            cand_q <= cand_q + LAT_W'(1);
            if (go_lock) begin
              // Leave the search state clean for a possible later relock.
              lock_q     <= 1'b1;
              lat_q      <= lock_lat;
              cand_q     <= '0;
              best_err_q <= '1;
              best_lat_q <= '0;
              bit_cnt_q  <= '0;
              err_cnt_q  <= '0;
            end
          end else begin
            win_cnt_q <= win_cnt_q + WCNT_W'(1);
            win_err_q <= win_total;
          end
        end else begin
          // Saturating counters; once bits saturate the error count freezes too.
          if (bit_cnt_q != '1) begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            if (err_cnt_q != '1) begin
              err_cnt_q <= err_cnt_q + CNT_W'(mismatch);
            end
          end
`ifdef BER_CHECKER_RELOCK_EN
          if (win_last) begin
            win_cnt_q <= '0;
            win_err_q <= '0;
          end else begin
            win_cnt_q <= win_cnt_q + WCNT_W'(1);
            win_err_q <= win_total;
          end
          if (go_search) begin
            // Delay line is intentionally kept; only measurement state restarts.
            lock_q    <= 1'b0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
          end
`endif
        end
      end
    end
  end

  assign bus.o_lock      = lock_q;
  assign bus.o_latency   = lat_q;
  assign bus.o_bit_count = bit_cnt_q;
  assign bus.o_err_count = err_cnt_q;

endmodule

// File: tb/tb_ber_checker.sv
// tb_ber_checker: randomized PRBS-like stimulus through a delay channel, checked against
// a per-candidate error-total reference model; a second instance with 4-bit counters
// exercises saturation.
module tb_ber_checker;

  localparam int WL      = 2;
  localparam int MAX_LAT = 16;
  localparam int WINDOW  = 64;
  localparam int TH      = 16;
  localparam int NSRCH   = MAX_LAT * WINDOW;

  logic i_clk = 1'b0;
  logic rst0;
  logic rst1;

  always #5 i_clk = ~i_clk;

  ber_checker_if #(.WL(WL), .MAX_LAT(MAX_LAT), .CNT_W(32)) bus0 ();
  ber_checker_if #(.WL(WL), .MAX_LAT(MAX_LAT), .CNT_W(4))  bus1 ();

  ber_checker #(.WL(WL), .MAX_LAT(MAX_LAT), .WINDOW(WINDOW), .CNT_W(32), .RELOCK_TH(TH))
    dut (.i_clk(i_clk), .i_reset(rst0), .bus(bus0));

  ber_checker #(.WL(WL), .MAX_LAT(MAX_LAT), .WINDOW(WINDOW), .CNT_W(4), .RELOCK_TH(TH))
    dut_sat (.i_clk(i_clk), .i_reset(rst1), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model (one slot per DUT) ----------------
  bit     m_valid [2];
  bit     m_lock  [2];
  int     m_lat   [2];
  longint m_bits  [2];
  longint m_errs  [2];
  longint m_max   [2];
  int     m_n     [2];          // enables into the current search
  int     m_cerr  [2][MAX_LAT]; // error total per candidate latency
  bit     m_hist  [2][32];      // reference history ring
  int     m_hn    [2];          // enables since reset
  int     m_wn    [2];
  int     m_we    [2];

  function automatic bit m_dly(int u, int k);
    if (k > m_hn[u] - 1) return 1'b0;
    return m_hist[u][(m_hn[u] - 1 - k) % 32];
  endfunction

  task automatic model_reset(int u);
    m_lock[u] = 0; m_lat[u] = 0; m_bits[u] = 0; m_errs[u] = 0;
    m_n[u] = 0; m_hn[u] = 0; m_wn[u] = 0; m_we[u] = 0;
    for (int c = 0; c < MAX_LAT; c++) m_cerr[u][c] = 0;
  endtask

  task automatic model_enable(int u, bit rx, bit rf);
    bit mm;
    int best;
    m_hist[u][m_hn[u] % 32] = rf;
    m_hn[u]++;
    if (!m_lock[u]) begin
      mm = rx ^ m_dly(u, m_n[u] / WINDOW);
      m_cerr[u][m_n[u] / WINDOW] += int'(mm);
      m_n[u]++;
      if (m_n[u] == NSRCH) begin
        best = 0;
        for (int c = 1; c < MAX_LAT; c++)
          if (m_cerr[u][c] < m_cerr[u][best]) best = c;
        m_lock[u] = 1; m_lat[u] = best; m_bits[u] = 0; m_errs[u] = 0;
        m_n[u] = 0; m_wn[u] = 0; m_we[u] = 0;
        for (int c = 0; c < MAX_LAT; c++) m_cerr[u][c] = 0;
      end
    end else begin
      mm = rx ^ m_dly(u, m_lat[u]);
      if (m_bits[u] < m_max[u]) begin
        m_bits[u]++;
        if (m_errs[u] < m_max[u]) m_errs[u] += longint'(mm);
      end
`ifdef BER_CHECKER_RELOCK_EN
      m_we[u] += int'(mm);
      m_wn[u]++;
      if (m_wn[u] == WINDOW) begin
        if (m_we[u] >= TH) begin
          m_lock[u] = 0; m_bits[u] = 0; m_errs[u] = 0;
        end
        m_wn[u] = 0; m_we[u] = 0;
      end
`endif
    end
  endtask

  task automatic compare(int u);
    logic [63:0] g_lock, g_lat, g_bits, g_errs;
    if (!m_valid[u]) return;
    if (u == 0) begin
      g_lock = 64'(bus0.o_lock); g_lat = 64'(bus0.o_latency);
      g_bits = 64'(bus0.o_bit_count); g_errs = 64'(bus0.o_err_count);
    end else begin
      g_lock = 64'(bus1.o_lock); g_lat = 64'(bus1.o_latency);
      g_bits = 64'(bus1.o_bit_count); g_errs = 64'(bus1.o_err_count);
    end
    check($sformatf("u%0d_lock", u), g_lock, 64'(m_lock[u]));
    if (m_lock[u]) check($sformatf("u%0d_latency", u), g_lat, 64'(m_lat[u]));
    check($sformatf("u%0d_bit_count", u), g_bits, m_bits[u]);
    check($sformatf("u%0d_err_count", u), g_errs, m_errs[u]);
  endtask

  // One cycle: check outputs of unit u, then present the next inputs to it.
  task automatic drive(int u, bit en, bit rst, bit rx, bit rf);
    @(negedge i_clk);
    compare(u);
    if (u == 0) begin
      rst0 = rst; bus0.i_enable = en; bus0.i_ref_bit = rf;
      bus0.i_rx_sym = {rx, 1'($urandom)};
      bus1.i_enable = 1'b0; rst1 = 1'b0;
    end else begin
      rst1 = rst; bus1.i_enable = en; bus1.i_ref_bit = rf;
      bus1.i_rx_sym = {rx, 1'($urandom)};
      bus0.i_enable = 1'b0; rst0 = 1'b0;
    end
    if (rst) model_reset(u);
    else if (en) model_enable(u, rx, rf);
  endtask

  logic [31:0] tx_sr = '0;

  task automatic sym(int lat, bit flip);
    bit rf;
    rf    = 1'($urandom);
    tx_sr = {tx_sr[30:0], rf};
    drive(0, 1'b1, 1'b0, tx_sr[lat] ^ flip, rf);
  endtask

  task automatic idle(int u);
    drive(u, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_unit(int u);
    drive(u, 1'b0, 1'b1, 1'b0, 1'b0);
    m_valid[u] = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog bound expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    m_max[0] = 64'hFFFF_FFFF;
    m_max[1] = 15;
    m_valid[0] = 0; m_valid[1] = 0;
    model_reset(0); model_reset(1);
    rst0 = 1'b1; rst1 = 1'b1;
    bus0.i_enable = 1'b0; bus0.i_rx_sym = '0; bus0.i_ref_bit = 1'b0;
    bus1.i_enable = 1'b0; bus1.i_rx_sym = '0; bus1.i_ref_bit = 1'b0;

    // Reset state
    reset_unit(0);
    idle(0);
    check("rst_lock", 64'(bus0.o_lock), 64'd0);
    check("rst_latency", 64'(bus0.o_latency), 64'd0);
    check("rst_bits", 64'(bus0.o_bit_count), 64'd0);
    check("rst_errs", 64'(bus0.o_err_count), 64'd0);

    // Latency 5, no errors, enable every cycle
    for (int i = 0; i < NSRCH; i++) sym(5, 1'b0);
    check("t1_prelock", 64'(bus0.o_lock), 64'd0);
    idle(0);
    check("t1_lock", 64'(bus0.o_lock), 64'd1);
    check("t1_latency", 64'(bus0.o_latency), 64'd5);
    check("t1_bits0", 64'(bus0.o_bit_count), 64'd0);
    for (int i = 0; i < 1000; i++) sym(5, 1'b0);
    idle(0);
    check("t1_bits", 64'(bus0.o_bit_count), 64'd1000);
    check("t1_errs", 64'(bus0.o_err_count), 64'd0);

    // Latency 5, every 100th symbol after lock inverted
    reset_unit(0);
    for (int i = 0; i < NSRCH; i++) sym(5, 1'b0);
    for (int i = 0; i < 1000; i++) sym(5, (i % 100) == 99);
    idle(0);
    check("t2_latency", 64'(bus0.o_latency), 64'd5);
    check("t2_bits", 64'(bus0.o_bit_count), 64'd1000);
    check("t2_errs", 64'(bus0.o_err_count), 64'd10);

    // Latency 11, enable one cycle in three
    reset_unit(0);
    for (int i = 0; i < NSRCH; i++) begin
      sym(11, 1'b0); idle(0); idle(0);
    end
    check("t3_lock", 64'(bus0.o_lock), 64'd1);
    check("t3_latency", 64'(bus0.o_latency), 64'd11);
    for (int i = 0; i < 30; i++) begin
      sym(11, 1'b0); idle(0); idle(0);
    end
    check("t3_bits", 64'(bus0.o_bit_count), 64'd30);

    // Reset (with enable) mid-search, then latency 3
    reset_unit(0);
    for (int i = 0; i < 500; i++) sym(7, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(0);
    check("t4_rst_lock", 64'(bus0.o_lock), 64'd0);
    for (int i = 0; i < NSRCH; i++) sym(3, 1'b0);
    check("t4_prelock", 64'(bus0.o_lock), 64'd0);
    idle(0);
    check("t4_lock", 64'(bus0.o_lock), 64'd1);
    check("t4_latency", 64'(bus0.o_latency), 64'd3);
    check("t4_bits", 64'(bus0.o_bit_count), 64'd0);
    check("t4_errs", 64'(bus0.o_err_count), 64'd0);

`ifdef BER_CHECKER_RELOCK_EN
    // Lock at 5, channel moves to 9: relock
    begin
      int k;
      reset_unit(0);
      for (int i = 0; i < NSRCH; i++) sym(5, 1'b0);
      for (int i = 0; i < 100; i++) sym(5, 1'b0);
      idle(0);
      check("rl_latency5", 64'(bus0.o_latency), 64'd5);
      k = 0;
      while (m_lock[0] && k < 400) begin
        sym(9, 1'b0);
        k++;
      end
      idle(0);
      check("rl_drop", 64'(bus0.o_lock), 64'd0);
      check("rl_drop_bound", 64'(k < 400), 64'd1);
      check("rl_bits_clr", 64'(bus0.o_bit_count), 64'd0);
      for (int i = 0; i < NSRCH; i++) sym(9, 1'b0);
      idle(0);
      check("rl_lock", 64'(bus0.o_lock), 64'd1);
      check("rl_latency9", 64'(bus0.o_latency), 64'd9);
    end
`endif

    // CNT_W=4, latency 0, every decision inverted: saturation
    reset_unit(1);
    for (int i = 0; i < NSRCH; i++) drive(1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    check("t5_lock", 64'(bus1.o_lock), 64'd1);
    check("t5_latency", 64'(bus1.o_latency), 64'd0);
    for (int i = 0; i < 15; i++) drive(1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    check("t5_bits_sat", 64'(bus1.o_bit_count), 64'd15);
    check("t5_errs_sat", 64'(bus1.o_err_count), 64'd15);
    for (int i = 0; i < 20; i++) drive(1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    check("t5_bits_hold", 64'(bus1.o_bit_count), 64'd15);
    check("t5_errs_hold", 64'(bus1.o_err_count), 64'd15);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
